// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus generator and response checker for a small
// combinational gate. Walks every input vector, holds each one for
// SETTLE_CYCLES, samples the gate output for one cycle and compares it
// against TRUTH_TABLE. All outputs are registered.
module gate_vector_checker #(
  parameter int                       N_INPUTS      = 2,
  parameter logic [2**N_INPUTS-1:0]   TRUTH_TABLE   = 4'b0111,
  parameter int                       SETTLE_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                dut_out,
  output logic [N_INPUTS-1:0] dut_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   error_count,
  output logic                mismatch,
  output logic [N_INPUTS-1:0] fail_vector
);

  // settle counter only needs to reach SETTLE_CYCLES-1
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST    = {N_INPUTS{1'b1}};

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t              state;
  logic [N_INPUTS-1:0] vec;
  logic [SW-1:0]       settle_cnt;
  logic                miss;

  // response compare against the expected truth-table bit for this vector
  always_comb miss = (dut_out != TRUTH_TABLE[vec]);

  // sequencer: IDLE -> (APPLY -> SAMPLE) per vector -> DONE
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      vec         <= '0;
      settle_cnt  <= '0;
      dut_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= '0;
      mismatch    <= 1'b0;
      fail_vector <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // start while idle or done begins a fresh run; fail_vector keeps
          // the last failure until a new one overwrites it
          if (start) begin
            state       <= APPLY;
            vec         <= '0;
            settle_cnt  <= '0;
            dut_in      <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            error_count <= '0;
          end
        end
        APPLY: begin
          settle_cnt <= settle_cnt + SW'(1);
          if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          if (miss) begin
            error_count <= error_count + (N_INPUTS+1)'(1);
            mismatch    <= 1'b1;
            fail_vector <= vec;
          end
          if (vec == VEC_LAST) begin
            // last vector never wraps; pass folds in this final compare
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            dut_in <= '0;
            pass   <= (error_count == '0) && !miss;
          end else begin
            state      <= APPLY;
            vec        <= vec + N_INPUTS'(1);
            dut_in     <= vec + N_INPUTS'(1);
            settle_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three instances (default NAND table,
// AND table, NAND with SETTLE_CYCLES=3), each fed by a behavioural gate
// whose behaviour is selectable (correct NAND, stuck-at-1, AND).
module tb_gate_vector_checker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] start = '0;
  logic [2:0] gout;
  logic [2:0] busy, done, pass, mism;
  logic [1:0] din [3];
  logic [1:0] fv  [3];
  logic [2:0] ec  [3];

  int mode [3] = '{0, 2, 0};
  logic [3:0] tt [3] = '{4'b0111, 4'b1000, 4'b0111};
  int settle [3] = '{1, 1, 3};

  int n_chk = 0;
  int n_pass = 0;

  int exp_in_q[$];
  int exp_fail_q[$];
  int exp_err_q[$];
  int exp_pass_q[$];

  always #5 clock = ~clock;

  gate_vector_checker u_nand (
    .clock(clock), .reset_n(reset_n), .start(start[0]), .dut_out(gout[0]),
    .dut_in(din[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .error_count(ec[0]), .mismatch(mism[0]), .fail_vector(fv[0]));

  gate_vector_checker #(.TRUTH_TABLE(4'b1000)) u_and (
    .clock(clock), .reset_n(reset_n), .start(start[1]), .dut_out(gout[1]),
    .dut_in(din[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .error_count(ec[1]), .mismatch(mism[1]), .fail_vector(fv[1]));

  gate_vector_checker #(.SETTLE_CYCLES(3)) u_s3 (
    .clock(clock), .reset_n(reset_n), .start(start[2]), .dut_out(gout[2]),
    .dut_in(din[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .error_count(ec[2]), .mismatch(mism[2]), .fail_vector(fv[2]));

  // mode 0 = NAND, 1 = stuck at 1, 2 = AND; v[1] is in1, v[0] is in2
  function automatic logic gate(input int m, input logic [1:0] v);
    case (m)
      0:       return ~(v[1] & v[0]);
      1:       return 1'b1;
      default: return v[1] & v[0];
    endcase
  endfunction

  always_comb begin
    gout = '0;
    for (int i = 0; i < 3; i++) gout[i] = gate(mode[i], din[i]);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One run on instance i with gate mode m. hold keeps start high through
  // DONE, poke_t re-asserts start mid-run, rst_t pulls reset at that cycle.
  // t counts edges after the one that sampled start.
  task automatic run(input int i, input int m, input bit hold,
                     input int poke_t, input int rst_t);
    int total, err, lim;
    logic [1:0] v;
    mode[i] = m;
    err = 0;
    for (int k = 0; k < 4; k++) begin
      v = k[1:0];
      repeat (settle[i] + 1) exp_in_q.push_back(k);
      if (gate(m, v) != tt[i][k]) begin
        exp_fail_q.push_back(k);
        err++;
      end
    end
    exp_err_q.push_back(err);
    exp_pass_q.push_back(err == 0);
    total = 4 * (settle[i] + 1);
    lim = hold ? total + 1 : total;

    @(negedge clock);
    start[i] = 1'b1;
    @(posedge clock);
    for (int t = 0; t <= lim; t++) begin
      @(negedge clock);
      start[i] = hold || (t == poke_t);
      if (mism[i]) begin
        if (exp_fail_q.size() == 0) chk("extra_mismatch", int'(mism[i]), 0);
        else chk("fail_vector", int'(fv[i]), exp_fail_q.pop_front());
      end
      if (t < total) begin
        chk("busy", int'(busy[i]), 1);
        chk("dut_in", int'(din[i]), exp_in_q.pop_front());
        if (t == rst_t) begin
          reset_n = 1'b0;
          start[i] = 1'b0;
          @(negedge clock);
          reset_n = 1'b1;
          chk("rst_dut_in", int'(din[i]), 0);
          chk("rst_busy", int'(busy[i]), 0);
          chk("rst_done", int'(done[i]), 0);
          chk("rst_pass", int'(pass[i]), 0);
          chk("rst_err", int'(ec[i]), 0);
          chk("rst_mism", int'(mism[i]), 0);
          chk("rst_fail_vec", int'(fv[i]), 0);
          exp_in_q.delete();
          exp_fail_q.delete();
          exp_err_q.delete();
          exp_pass_q.delete();
          return;
        end
      end else if (t == total) begin
        chk("done_at_latency", int'(done[i]), 1);
        chk("busy_at_done", int'(busy[i]), 0);
        chk("dut_in_at_done", int'(din[i]), 0);
        chk("error_count", int'(ec[i]), exp_err_q.pop_front());
        chk("pass", int'(pass[i]), exp_pass_q.pop_front());
      end else begin
        chk("restart_busy", int'(busy[i]), 1);
        chk("restart_done", int'(done[i]), 0);
        chk("restart_dut_in", int'(din[i]), 0);
      end
    end
    chk("missing_mismatch", exp_fail_q.size(), 0);
    chk("queue_drained", exp_in_q.size(), 0);
    exp_fail_q.delete();
    exp_in_q.delete();
    if (hold) begin
      start[i] = 1'b0;
      pulse_reset();
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_dut_in", int'(din[0]), 0);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_done", int'(done[0]), 0);
    chk("reset_pass", int'(pass[0]), 0);
    chk("reset_err", int'(ec[0]), 0);
    chk("reset_fail_vec", int'(fv[0]), 0);
    reset_n = 1'b1;

    run(0, 0, 1'b0, -1, -1);   // correct NAND
    run(0, 1, 1'b0, -1, -1);   // stuck at 1
    run(0, 0, 1'b0, -1, 4);    // reset while vec=2
    run(0, 0, 1'b0, -1, -1);   // clean run after reset
    run(0, 0, 1'b0, 3, -1);    // start while busy
    run(0, 0, 1'b1, -1, -1);   // start held high
    run(0, 2, 1'b0, -1, -1);   // AND against NAND table
    run(1, 2, 1'b0, -1, -1);   // AND against AND table
    run(2, 0, 1'b0, -1, -1);   // SETTLE_CYCLES=3

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Synthesizable stimulus generator and response checker for a small combinational gate under test, such as the lab nand_gate.
- Upstream, it drives every input combination exhaustively. Downstream, it samples the gate output and compares it against a parameterised truth table.
- It counts mismatches and reports pass/fail, so on-board gate checks need no simulator testbench.

Parameters:
- N_INPUTS, 2, number of gate inputs; vectors run 0 .. 2^N_INPUTS-1.
- TRUTH_TABLE, 4'b0111, expected output per vector; bit k is the expected output for vector k; width 2^N_INPUTS; default is NAND.
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; must be >= 1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  level-sampled run request.
- dut_out  input  1  output of the gate under test.
- dut_in  output  N_INPUTS  registered input vector to the gate; vector bit N_INPUTS-1 drives in1.
- busy  output  1  high while a run is in progress.
- done  output  1  high when a run has completed; held until the next run.
- pass  output  1  meaningful only while done=1; 1 iff error_count==0.
- error_count  output  N_INPUTS+1  mismatches counted this run; width holds the maximum 2^N_INPUTS without overflow.
- mismatch  output  1  one-cycle pulse per failing vector.
- fail_vector  output  N_INPUTS  vector of the most recent mismatch; holds its value between pulses.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE.
  - dut_in, busy, done, pass, error_count, mismatch and fail_vector all go to 0.
  - Reset has priority over every other input, including mid-run; no partial results survive.
- IDLE:
  - dut_in=0, busy=0.
  - start=1 at an edge → APPLY with vec=0, settle_cnt=0, error_count=0, done=0, pass=0.
- APPLY:
  - dut_in=vec, busy=1.
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE (exactly one cycle):
  - dut_in still equals vec.
  - At the edge leaving SAMPLE, dut_out is compared with TRUTH_TABLE[vec].
  - On inequality: error_count+1, mismatch=1 for the next cycle, fail_vector=vec.
  - If vec==2^N_INPUTS-1 → DONE. Otherwise vec+1, settle_cnt=0 → APPLY.
- DONE:
  - dut_in=0, busy=0, done=1, pass=(error_count==0).
  - error_count and fail_vector hold.
  - start=1 → new run, identical to the IDLE transition; done and pass clear on that same edge.
- Per-vector cost: SETTLE_CYCLES+1 cycles.
- Latency: done rises 2^N_INPUTS*(SETTLE_CYCLES+1) cycles after the edge that sampled start. Defaults give 8 cycles.
- Boundary and ordering rules:
  - start while busy is ignored.
  - start held high continuously restarts immediately from DONE; DONE therefore lasts one cycle.
  - vec must not wrap: the last vector always exits to DONE.
  - The mismatch pulse of the final vector coincides with the first DONE cycle.
  - error_count cannot saturate, given its width.
- Comparison is plain equality on the sampled bit. No combinational path exists from dut_out to any output.

Test Plan:
- Correct nand_gate, defaults, start pulsed one cycle:
  - dut_in steps 00,00,01,01,10,10,11,11 (2 cycles each).
  - done=1 and pass=1 exactly 8 cycles after start.
  - error_count=0; mismatch never pulses.
- DUT output stuck at 1:
  - Exactly one mismatch pulse, fail_vector=2'b11.
  - error_count=1, pass=0 at done.
- AND gate with default TRUTH_TABLE:
  - 4 mismatch pulses, fail_vector ends at 2'b11.
  - error_count=4 (3'b100), pass=0.
  - Rerun with TRUTH_TABLE=4'b1000 → pass=1.
- reset_n=0 for one cycle while vec=2:
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent start completes a full clean run: pass=1 after 8 cycles.
- start pulsed while busy: no effect; done still arrives at cycle 8.
- start held high: immediate restart after one DONE cycle.
- SETTLE_CYCLES=3 with correct NAND: each vector held 4 cycles; done at cycle 16; pass=1.
